// File: rtl/commit_mon_pkg.sv
// Shared types and width helpers for the commit monitor.
// The optional alignment check is enabled by defining COMMIT_MON_ALIGN_CHK_EN.
package commit_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    // Number of bits needed to encode values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/commit_mon_chan.sv
// One monitored commit stream: FSM, retire/stall/repeat counters and PC history RAM.
// With COMMIT_MON_ALIGN_CHK_EN defined, a misaligned commit PC is flagged and ends the run.
module commit_mon_chan
    import commit_mon_pkg::*;
#(
    parameter int  PC_W        = 32,
    parameter int  CNT_W       = 32,
    parameter int  HIST_DEPTH  = 8,
    parameter int  TIMEOUT     = 1024,
    parameter int  HALT_REPEAT = 4,
    localparam int IDX_W       = clog2_min1(HIST_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             insn_vld,
    input  logic [PC_W-1:0]  pc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_pc,
    output logic             rd_vld,
    output logic [CNT_W-1:0] retired,
    output logic             halt,
    output logic             timeout
`ifdef COMMIT_MON_ALIGN_CHK_EN
    ,
    output logic             align_err
`endif
);

    localparam int PTR_W   = clog2_min1(HIST_DEPTH);
    localparam int FILL_W  = clog2_min1(HIST_DEPTH + 1);
    localparam int STALL_W = clog2_min1(TIMEOUT + 1);
    localparam int REP_W   = clog2_min1(HALT_REPEAT + 1);

    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(HIST_DEPTH);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
    localparam logic [REP_W-1:0]   REP_MAX   = REP_W'(HALT_REPEAT);

    mon_state_e         state_r, state_nxt_s;
    logic [STALL_W-1:0] stall_r, stall_nxt_s;
    logic [REP_W-1:0]   rep_r, rep_nxt_s;
    logic [PC_W-1:0]    last_pc_r, last_pc_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_nxt_s, rd_ptr_s;
    logic [FILL_W-1:0]  fill_r, fill_nxt_s;
    logic [CNT_W-1:0]   retired_r, retired_nxt_s;
    logic               halt_r, halt_nxt_s;
    logic               timeout_r, timeout_nxt_s;
    logic               hist_we_s;
    logic               srst_s;
    logic [PC_W-1:0]    mem_r [HIST_DEPTH];
`ifdef COMMIT_MON_ALIGN_CHK_EN
    logic               align_err_r, align_nxt_s;
`endif

    assign srst_s = reset | clear;

    // Next-state and counter update for one commit stream.
    always_comb begin
        state_nxt_s   = state_r;
        stall_nxt_s   = stall_r;
        rep_nxt_s     = rep_r;
        last_pc_nxt_s = last_pc_r;
        wr_ptr_nxt_s  = wr_ptr_r;
        fill_nxt_s    = fill_r;
        retired_nxt_s = retired_r;
        halt_nxt_s    = halt_r;
        timeout_nxt_s = timeout_r;
        hist_we_s     = 1'b0;
`ifdef COMMIT_MON_ALIGN_CHK_EN
        align_nxt_s   = align_err_r;
`endif
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (insn_vld) begin
                    stall_nxt_s   = {STALL_W{1'b0}};
                    hist_we_s     = 1'b1;
                    wr_ptr_nxt_s  = wr_ptr_r + PTR_W'(1);
                    last_pc_nxt_s = pc;
                    if (fill_r != FILL_MAX) begin
                        fill_nxt_s = fill_r + FILL_W'(1);
                    end else begin
                        fill_nxt_s = fill_r;
                    end
                    if (retired_r != {CNT_W{1'b1}}) begin
                        retired_nxt_s = retired_r + CNT_W'(1);
                    end else begin
                        retired_nxt_s = retired_r;
                    end
                    // The first commit after reset has no previous PC to match against.
                    if (state_r == ST_IDLE) begin
                        rep_nxt_s = REP_W'(1);
                    end else if (pc != last_pc_r) begin
                        rep_nxt_s = REP_W'(1);
                    end else if (rep_r != REP_MAX) begin
                        rep_nxt_s = rep_r + REP_W'(1);
                    end else begin
                        rep_nxt_s = rep_r;
                    end
                    if ((state_r == ST_RUN) && (rep_nxt_s == REP_MAX)) begin
                        state_nxt_s = ST_HALT;
                        halt_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`ifdef COMMIT_MON_ALIGN_CHK_EN
                    if (pc[1:0] != 2'b00) begin
                        align_nxt_s   = 1'b1;
                        timeout_nxt_s = 1'b1;
                        halt_nxt_s    = halt_r;
                        state_nxt_s   = ST_TIMEOUT;
                    end else begin
                        align_nxt_s   = align_err_r;
                    end
`endif
                end else if (stall_r == STALL_MAX) begin
                    state_nxt_s   = ST_TIMEOUT;
                    timeout_nxt_s = 1'b1;
                end else begin
                    stall_nxt_s = stall_r + STALL_W'(1);
                end
            end
            ST_HALT, ST_TIMEOUT: begin
                state_nxt_s = state_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset and clear override any commit.
    always_ff @(posedge clk) begin
        if (srst_s) begin
            state_r     <= ST_IDLE;
            stall_r     <= {STALL_W{1'b0}};
            rep_r       <= {REP_W{1'b0}};
            last_pc_r   <= {PC_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            retired_r   <= {CNT_W{1'b0}};
            halt_r      <= 1'b0;
            timeout_r   <= 1'b0;
`ifdef COMMIT_MON_ALIGN_CHK_EN
            align_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            stall_r     <= stall_nxt_s;
            rep_r       <= rep_nxt_s;
            last_pc_r   <= last_pc_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            fill_r      <= fill_nxt_s;
            retired_r   <= retired_nxt_s;
            halt_r      <= halt_nxt_s;
            timeout_r   <= timeout_nxt_s;
`ifdef COMMIT_MON_ALIGN_CHK_EN
            align_err_r <= align_nxt_s;
`endif
        end
    end

    // History RAM write port; contents need no reset because the fill count gates reads.
    always_ff @(posedge clk) begin
        if (hist_we_s && !srst_s) begin
            mem_r[wr_ptr_r] <= pc;
        end
    end

    // History read: index 0 is the entry just behind the write pointer.
    always_comb begin
        rd_ptr_s = wr_ptr_r - PTR_W'(1) - rd_idx;
        if (FILL_W'(rd_idx) < fill_r) begin
            rd_vld = 1'b1;
            rd_pc  = mem_r[rd_ptr_s];
        end else begin
            rd_vld = 1'b0;
            rd_pc  = {PC_W{1'b0}};
        end
    end

    assign retired   = retired_r;
    assign halt      = halt_r;
    assign timeout   = timeout_r;
`ifdef COMMIT_MON_ALIGN_CHK_EN
    assign align_err = align_err_r;
`endif

endmodule

// File: rtl/commit_monitor.sv
// Multi-channel RISC-V commit monitor: per-channel halt/timeout detection plus PC history readout.
// Define COMMIT_MON_ALIGN_CHK_EN to add the o_align_err port and misaligned-PC detection.
module commit_monitor
    import commit_mon_pkg::*;
#(
    parameter int  NUM_CH      = 1,
    parameter int  PC_W        = 32,
    parameter int  CNT_W       = 32,
    parameter int  HIST_DEPTH  = 8,
    parameter int  TIMEOUT     = 1024,
    parameter int  HALT_REPEAT = 4,
    localparam int HCH_W       = clog2_min1(NUM_CH),
    localparam int IDX_W       = clog2_min1(HIST_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic [NUM_CH-1:0]       i_insn_vld,
    input  logic [NUM_CH*PC_W-1:0]  i_pc,
    input  logic [HCH_W-1:0]        i_hist_ch,
    input  logic [IDX_W-1:0]        i_hist_idx,
    output logic [PC_W-1:0]         o_hist_pc,
    output logic                    o_hist_vld,
    output logic [NUM_CH*CNT_W-1:0] o_retired,
    output logic [NUM_CH-1:0]       o_halt,
    output logic [NUM_CH-1:0]       o_timeout,
    output logic                    o_done
`ifdef COMMIT_MON_ALIGN_CHK_EN
    ,
    output logic [NUM_CH-1:0]       o_align_err
`endif
);

    logic [PC_W-1:0]   chan_pc_s [NUM_CH];
    logic [NUM_CH-1:0] chan_vld_s;
    logic [PC_W-1:0]   sel_pc_s;
    logic              sel_vld_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        commit_mon_chan #(
            .PC_W        (PC_W),
            .CNT_W       (CNT_W),
            .HIST_DEPTH  (HIST_DEPTH),
            .TIMEOUT     (TIMEOUT),
            .HALT_REPEAT (HALT_REPEAT)
        ) u_chan (
            .clk       (i_clk),
            .reset     (i_reset),
            .clear     (i_clear),
            .insn_vld  (i_insn_vld[k]),
            .pc        (i_pc[k*PC_W +: PC_W]),
            .rd_idx    (i_hist_idx),
            .rd_pc     (chan_pc_s[k]),
            .rd_vld    (chan_vld_s[k]),
            .retired   (o_retired[k*CNT_W +: CNT_W]),
            .halt      (o_halt[k]),
            .timeout   (o_timeout[k])
`ifdef COMMIT_MON_ALIGN_CHK_EN
            ,
            .align_err (o_align_err[k])
`endif
        );
    end

    // Channel select for history readout; an out-of-range channel selects nothing.
    always_comb begin
        sel_pc_s  = {PC_W{1'b0}};
        sel_vld_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_pc_s  = sel_pc_s | ((HCH_W'(k) == i_hist_ch) ? chan_pc_s[k] : {PC_W{1'b0}});
            sel_vld_s = sel_vld_s | ((HCH_W'(k) == i_hist_ch) & chan_vld_s[k]);
        end
    end

    // Registered history read data.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            o_hist_pc  <= {PC_W{1'b0}};
            o_hist_vld <= 1'b0;
        end else begin
            o_hist_pc  <= sel_pc_s;
            o_hist_vld <= sel_vld_s;
        end
    end

    assign o_done = &(o_halt | o_timeout);

endmodule
